// File: rtl/core_input_buf_if.sv
// Core-side bus of the per-core input block buffer: write/commit from the address
// generator, read/release from the schedule engine, and committed slot status.
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 2
`endif

interface core_input_buf_if #(
   parameter int WIDTH    = 64,
   parameter int BLK_OP_W = `BLK_OP_MSB + 1
);
   logic                     wr_en;
   logic [3:0]               wr_addr;
   logic [WIDTH-1:0]         din;
   logic [BLK_OP_W-1:0]      in_blk_op;
   logic                     in_ctx;
   logic                     in_seq;
   logic                     set_input_ready;
   logic                     rd_en;
   logic                     rd_seq;
   logic [3:0]               rd_addr;
   logic [WIDTH-1:0]         dout;
   logic                     dout_valid;
   // "release" is a reserved word, hence release_req
   logic                     release_req;
   logic                     release_seq;
   logic [1:0]               slot_ready;
   logic [1:0][BLK_OP_W-1:0] slot_blk_op;
   logic [1:0]               slot_ctx;
   logic                     err_overflow;
   logic                     err_short;

   modport master (
      output wr_en, wr_addr, din, in_blk_op, in_ctx, in_seq, set_input_ready,
             rd_en, rd_seq, rd_addr, release_req, release_seq,
      input  dout, dout_valid, slot_ready, slot_blk_op, slot_ctx,
             err_overflow, err_short
   );

   modport slave (
      input  wr_en, wr_addr, din, in_blk_op, in_ctx, in_seq, set_input_ready,
             rd_en, rd_seq, rd_addr, release_req, release_seq,
      output dout, dout_valid, slot_ready, slot_blk_op, slot_ctx,
             err_overflow, err_short
   );
endinterface

// File: rtl/core_input_buf.sv
// Two-slot, 16-word message block buffer between the write-address generator
// and the SHA-512 schedule engine; slots cycle EMPTY -> FILLING -> READY -> EMPTY.
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 2
`endif

module core_input_buf #(
   parameter int WIDTH    = 64,
   parameter int BLK_OP_W = `BLK_OP_MSB + 1
) (
   input logic               CLK,
   input logic               reset,
   core_input_buf_if.slave   bus
);
   logic [WIDTH-1:0] mem [32];
   logic [1:0][15:0] mask;
   logic             wr_ok;
   logic [15:0]      mask_now;

   // Commit's completeness test must see a word written in the same cycle
   always_comb begin
      wr_ok    = bus.wr_en && !bus.slot_ready[bus.in_seq];
      mask_now = mask[bus.in_seq];
      if (wr_ok)
         mask_now = mask_now | (16'd1 << bus.wr_addr);
   end

   always_ff @(posedge CLK) begin
      if (wr_ok)
         mem[{bus.in_seq, bus.wr_addr}] <= bus.din;
   end

   always_ff @(posedge CLK) begin
      if (bus.rd_en)
         bus.dout <= mem[{bus.rd_seq, bus.rd_addr}];
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         bus.dout_valid   <= 1'b0;
         bus.slot_ready   <= '0;
         bus.slot_blk_op  <= '0;
         bus.slot_ctx     <= '0;
         bus.err_overflow <= 1'b0;
         bus.err_short    <= 1'b0;
         mask             <= '0;
      end else begin
         bus.dout_valid <= bus.rd_en;

         if (bus.release_req)
            bus.slot_ready[bus.release_seq] <= 1'b0;

         if (bus.wr_en) begin
            if (bus.slot_ready[bus.in_seq])
               bus.err_overflow <= 1'b1;
            else
               mask[bus.in_seq] <= mask_now;
         end

         // Commit decisions use pre-release slot_ready, so a same-cycle release
         // never lets a write or commit land in the freed slot
         if (bus.set_input_ready) begin
            if (bus.slot_ready[bus.in_seq]) begin
               bus.err_overflow <= 1'b1;
            end else begin
               mask[bus.in_seq] <= '0;
               if (mask_now == 16'hFFFF) begin
                  bus.slot_ready[bus.in_seq]  <= 1'b1;
                  bus.slot_blk_op[bus.in_seq] <= bus.in_blk_op;
                  bus.slot_ctx[bus.in_seq]    <= bus.in_ctx;
               end else begin
                  bus.err_short <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_core_input_buf.sv
// Randomised bench for core_input_buf against a set/array reference model of the
// slot rules; directed scenarios plus a random soak.
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 2
`endif

module tb_core_input_buf;
   localparam int W  = 64;
   localparam int BW = `BLK_OP_MSB + 1;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   core_input_buf_if #(.WIDTH(W), .BLK_OP_W(BW)) bus ();
   core_input_buf #(.WIDTH(W), .BLK_OP_W(BW)) dut (.CLK(CLK), .reset(reset), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [W-1:0]  m_mem [32];
   bit            m_known [32];
   bit            m_wr [2][16];
   bit            m_rdy [2];
   logic [BW-1:0] m_op [2];
   bit            m_ctx [2];
   bit            m_eo, m_es, m_dv, m_dk;
   logic [W-1:0]  m_dout;

   task automatic idle();
      bus.wr_en = 0; bus.wr_addr = 0; bus.din = '0; bus.in_blk_op = '0;
      bus.in_ctx = 0; bus.in_seq = 0; bus.set_input_ready = 0;
      bus.rd_en = 0; bus.rd_seq = 0; bus.rd_addr = 0;
      bus.release_req = 0; bus.release_seq = 0;
   endtask

   // Advance one clock, applying the slot rules to whatever is being driven
   task automatic tick();
      bit rdy0 [2];
      bit full;
      @(posedge CLK);
      if (reset) begin
         m_rdy = '{0, 0}; m_op = '{0, 0}; m_ctx = '{0, 0};
         m_eo = 0; m_es = 0; m_dv = 0;
         foreach (m_wr[s, a]) m_wr[s][a] = 0;
      end else begin
         rdy0 = m_rdy;
         m_dv = bus.rd_en;
         if (bus.rd_en) begin
            m_dout = m_mem[{bus.rd_seq, bus.rd_addr}];
            m_dk   = m_known[{bus.rd_seq, bus.rd_addr}];
         end
         if (bus.release_req) m_rdy[bus.release_seq] = 0;
         if (bus.wr_en) begin
            if (rdy0[bus.in_seq]) m_eo = 1;
            else begin
               m_mem[{bus.in_seq, bus.wr_addr}]   = bus.din;
               m_known[{bus.in_seq, bus.wr_addr}] = 1;
               m_wr[bus.in_seq][bus.wr_addr]      = 1;
            end
         end
         if (bus.set_input_ready) begin
            if (rdy0[bus.in_seq]) m_eo = 1;
            else begin
               full = 1;
               for (int a = 0; a < 16; a++) full &= m_wr[bus.in_seq][a];
               if (full) begin
                  m_rdy[bus.in_seq] = 1;
                  m_op[bus.in_seq]  = bus.in_blk_op;
                  m_ctx[bus.in_seq] = bus.in_ctx;
               end else m_es = 1;
               for (int a = 0; a < 16; a++) m_wr[bus.in_seq][a] = 0;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1; tick(); tick();
      reset = 0;
   endtask

   // 16-word fill of one slot, commit on the last word
   task automatic fill(input bit seq, input bit ctx, input logic [BW-1:0] op);
      for (int i = 0; i < 16; i++) begin
         bus.wr_en = 1; bus.in_seq = seq; bus.wr_addr = 4'(i);
         bus.din = {$urandom, $urandom}; bus.in_ctx = ctx; bus.in_blk_op = op;
         bus.set_input_ready = (i == 15);
         tick();
      end
      idle();
   endtask

   task automatic test_reset();
      reset = 1; idle(); tick(); tick();
      n_tests++;
      if (bus.slot_ready !== 2'b00 || bus.slot_ctx !== 2'b00 || bus.slot_blk_op !== '0) begin
         n_fail++;
         $display("FAIL reset_slots: ready=%b ctx=%b op=%h want 0", bus.slot_ready, bus.slot_ctx, bus.slot_blk_op);
      end
      n_tests++;
      if ({bus.err_overflow, bus.err_short, bus.dout_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: eo/es/dv=%b want 000", {bus.err_overflow, bus.err_short, bus.dout_valid});
      end
      reset = 0;
   endtask

   task automatic test_full_fill();
      for (int i = 0; i < 16; i++) begin
         bus.wr_en = 1; bus.in_seq = 0; bus.wr_addr = 4'(i); bus.din = 64'h1000 + 64'(i);
         bus.in_ctx = 1; bus.in_blk_op = BW'(2); bus.set_input_ready = (i == 15);
         tick();
      end
      idle();
      n_tests++;
      if (bus.slot_ready !== 2'b01 || bus.slot_ctx[0] !== 1'b1 || bus.slot_blk_op[0] !== BW'(2)) begin
         n_fail++;
         $display("FAIL full_fill_commit: ready=%b ctx0=%b op0=%0d want 01/1/2", bus.slot_ready, bus.slot_ctx[0], bus.slot_blk_op[0]);
      end
      bus.rd_en = 1; bus.rd_seq = 0; bus.rd_addr = 7;
      tick();
      idle();
      n_tests++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 64'h1007) begin
         n_fail++;
         $display("FAIL full_fill_read: dv=%b dout=%h want 1/1007", bus.dout_valid, bus.dout);
      end
      tick();
      n_tests++;
      if (bus.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_fill_dv_drop: dv=%b want 0", bus.dout_valid);
      end
   endtask

   task automatic test_short();
      bus.release_req = 1; bus.release_seq = 0; tick(); idle();
      for (int i = 0; i < 15; i++) begin
         bus.wr_en = 1; bus.in_seq = 0; bus.wr_addr = 4'(i); bus.din = {$urandom, $urandom};
         tick();
      end
      idle();
      bus.set_input_ready = 1; bus.in_seq = 0; tick(); idle();
      n_tests++;
      if (bus.slot_ready !== 2'b00 || bus.err_short !== 1'b1) begin
         n_fail++;
         $display("FAIL short_block: ready=%b es=%b want 00/1", bus.slot_ready, bus.err_short);
      end
      fill(0, 0, BW'(5));
      n_tests++;
      if (bus.slot_ready !== 2'b01 || bus.slot_blk_op[0] !== BW'(5)) begin
         n_fail++;
         $display("FAIL short_refill: ready=%b op0=%0d want 01/5", bus.slot_ready, bus.slot_blk_op[0]);
      end
   endtask

   task automatic test_overflow();
      bus.wr_en = 1; bus.in_seq = 0; bus.wr_addr = 3; bus.din = 64'hDEAD; tick(); idle();
      n_tests++;
      if (bus.err_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_flag: eo=%b want 1", bus.err_overflow);
      end
      bus.rd_en = 1; bus.rd_seq = 0; bus.rd_addr = 3; tick(); idle();
      n_tests++;
      if (bus.dout !== m_mem[3] || bus.dout === 64'hDEAD) begin
         n_fail++;
         $display("FAIL overflow_data: dout=%h want %h", bus.dout, m_mem[3]);
      end
      bus.release_req = 1; bus.release_seq = 0; tick(); idle();
      n_tests++;
      if (bus.slot_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL overflow_release: ready=%b want 00", bus.slot_ready);
      end
      fill(0, 1, BW'(1));
      n_tests++;
      if (bus.slot_ready !== 2'b01 || bus.slot_ctx[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_refill: ready=%b ctx0=%b want 01/1", bus.slot_ready, bus.slot_ctx[0]);
      end
   endtask

   task automatic test_interleave();
      logic [BW-1:0] op = BW'($urandom);
      for (int i = 0; i < 16; i++) begin
         bus.wr_en = 1; bus.in_seq = 1; bus.wr_addr = 4'(i); bus.din = {$urandom, $urandom};
         bus.in_ctx = 0; bus.in_blk_op = op; bus.set_input_ready = (i == 15);
         bus.rd_en = 1; bus.rd_seq = 0; bus.rd_addr = 4'(i);
         tick();
         n_tests++;
         if (bus.dout_valid !== 1'b1 || bus.dout !== m_dout) begin
            n_fail++;
            $display("FAIL interleave_read[%0d]: dv=%b dout=%h want 1/%h", i, bus.dout_valid, bus.dout, m_dout);
         end
      end
      idle();
      n_tests++;
      if (bus.slot_ready !== 2'b11 || bus.slot_blk_op[1] !== op || bus.slot_ctx[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL interleave_commit: ready=%b op1=%0d ctx1=%b want 11/%0d/0", bus.slot_ready, bus.slot_blk_op[1], bus.slot_ctx[1], op);
      end
      bus.release_req = 1; bus.release_seq = 0; tick(); idle();
      n_tests++;
      if (bus.slot_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL interleave_release: ready=%b want 10", bus.slot_ready);
      end
   endtask

   task automatic test_release_write();
      do_reset();
      fill(0, 0, BW'(3));
      n_tests++;
      if (bus.err_overflow !== 1'b0 || bus.slot_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL relwr_setup: eo=%b ready=%b want 0/01", bus.err_overflow, bus.slot_ready);
      end
      bus.release_req = 1; bus.release_seq = 0;
      bus.wr_en = 1; bus.in_seq = 0; bus.wr_addr = 0; bus.din = 64'hBEEF;
      tick(); idle();
      n_tests++;
      if (bus.err_overflow !== 1'b1 || bus.slot_ready[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL relwr_same_cycle: eo=%b ready0=%b want 1/0", bus.err_overflow, bus.slot_ready[0]);
      end
      bus.rd_en = 1; bus.rd_seq = 0; bus.rd_addr = 0; tick(); idle();
      n_tests++;
      if (bus.dout !== m_mem[0] || bus.dout === 64'hBEEF) begin
         n_fail++;
         $display("FAIL relwr_dropped: dout=%h want %h", bus.dout, m_mem[0]);
      end
   endtask

   task automatic test_reset_mid_fill();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1; bus.in_seq = 0; bus.wr_addr = 4'(i); bus.din = {$urandom, $urandom};
         tick();
      end
      idle();
      reset = 1; tick(); reset = 0;
      for (int i = 8; i < 16; i++) begin
         bus.wr_en = 1; bus.in_seq = 0; bus.wr_addr = 4'(i); bus.din = {$urandom, $urandom};
         bus.set_input_ready = (i == 15);
         tick();
      end
      idle();
      n_tests++;
      if (bus.err_short !== 1'b1 || bus.slot_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_fill: es=%b ready=%b want 1/00", bus.err_short, bus.slot_ready);
      end
   endtask

   task automatic test_random();
      int cnt [2] = '{0, 0};
      do_reset();
      for (int c = 0; c < 600; c++) begin
         bit s = 1'($urandom);
         idle();
         bus.wr_en = ($urandom_range(0, 3) != 0);
         bus.in_seq = s;
         bus.wr_addr = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(cnt[s]);
         if (bus.wr_en) cnt[s] = (cnt[s] + 1) % 16;
         bus.din = {$urandom, $urandom};
         bus.in_blk_op = BW'($urandom); bus.in_ctx = 1'($urandom);
         bus.set_input_ready = ($urandom_range(0, 11) == 0) || (bus.wr_en && cnt[s] == 0);
         bus.rd_en = 1'($urandom); bus.rd_seq = 1'($urandom); bus.rd_addr = 4'($urandom);
         bus.release_req = ($urandom_range(0, 9) == 0); bus.release_seq = 1'($urandom);
         tick();
         n_tests++;
         if (bus.slot_ready !== {1'(m_rdy[1]), 1'(m_rdy[0])} || bus.slot_ctx !== {1'(m_ctx[1]), 1'(m_ctx[0])}
             || bus.slot_blk_op[0] !== m_op[0] || bus.slot_blk_op[1] !== m_op[1]
             || bus.err_overflow !== m_eo || bus.err_short !== m_es || bus.dout_valid !== m_dv
             || (m_dv && m_dk && bus.dout !== m_dout)) begin
            n_fail++;
            $display("FAIL random[%0d]: rdy=%b eo=%b es=%b dv=%b dout=%h want rdy=%b%b eo=%b es=%b dv=%b dout=%h",
                     c, bus.slot_ready, bus.err_overflow, bus.err_short, bus.dout_valid, bus.dout,
                     m_rdy[1], m_rdy[0], m_eo, m_es, m_dv, m_dout);
         end
      end
      idle();
   endtask

   initial begin
      foreach (m_known[i]) m_known[i] = 0;
      m_dk = 0; m_dout = '0;
      test_reset();
      test_full_fill();
      test_short();
      test_overflow();
      test_interleave();
      test_release_write();
      test_reset_mid_fill();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
